parity_stream_unit: RTL and testbench
=====================================

PARITY_STREAM_UNIT -- requirements
Module: parity_stream_unit

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, payload width in bits (legal 1..64).
REQ-002 SHALL provide parameter ODD, default 0, parity sense (0 = even, 1 = odd).
REQ-003 SHALL provide parameter CNT_W, default 8, error-counter width in bits.
REQ-004 SHALL provide port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL provide port mode  input  1  0 = generate parity, 1 = check parity; sampled with each accepted beat.
REQ-007 SHALL provide port in_valid  input  1  upstream beat valid.
REQ-008 SHALL provide port in_ready  output  1  unit can accept a beat this cycle.
REQ-009 SHALL provide port in_data  input  DATA_W  payload.
REQ-010 SHALL provide port in_parity  input  1  received parity bit; used in check mode only.
REQ-011 SHALL provide port out_valid  output  1  registered beat available.
REQ-012 SHALL provide port out_ready  input  1  downstream accepts the beat.
REQ-013 SHALL provide port out_data  output  DATA_W  registered payload.
REQ-014 SHALL provide port out_parity  output  1  generated parity (generate mode) or received parity (check mode).
REQ-015 SHALL provide port out_ok  output  1  1 in generate mode; parity-match result in check mode.
REQ-016 SHALL provide port err_sticky  output  1  latched parity-failure flag.
REQ-017 SHALL provide port err_clr  input  1  clears err_sticky and the error counter.

Function
REQ-018 SHALL implement a one-entry output stage with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-020 SHALL accept a beat when in_valid && in_ready; the beat appears on the outputs with out_valid=1 on the next cycle (1-cycle latency).
REQ-021 SHALL transition EMPTY->FULL on accept; FULL->EMPTY on out_ready with no accept; stay FULL when out_ready and an accept occur in the same cycle (1 beat/cycle sustained).
REQ-022 SHALL hold out_data, out_parity and out_ok stable while out_valid && !out_ready.
REQ-023 In generate mode, SHALL set out_parity = XOR-reduce(in_data) XOR ODD, and out_ok = 1.
REQ-024 In check mode, SHALL set out_parity = in_parity, and out_ok = 1 iff XOR-reduce({in_data,in_parity}) == ODD.
REQ-025 SHALL set err_sticky on any check-mode accept with a failed check; err_clr clears it; a simultaneous set and err_clr leaves it set.
REQ-026 SHALL ignore in_data, in_parity and mode when no accept occurs.

Reset
REQ-027 With rst=1 at a clock edge, SHALL clear out_valid, out_data, out_parity, out_ok, err_sticky and the error counter to 0.
REQ-028 With rst=1, SHALL drive in_ready=1; a beat held in FULL is discarded; any beat presented during the reset cycle is dropped.

Configuration
REQ-029 With macro PARITY_ERR_CNT_EN defined, SHALL add output err_count (CNT_W) counting failed check-mode accepts, saturating at 2^CNT_W-1, cleared by err_clr, and reading 1 when a failure and err_clr coincide.
REQ-030 Without PARITY_ERR_CNT_EN, SHALL omit port err_count and its counter logic; all other behaviour stays identical.

Verification (DATA_W=8, ODD=0 unless stated)
REQ-031 Generate mode: mode=0, in_data=0x07, out_ready=1 -> next cycle out_valid=1, out_data=0x07, out_parity=1, out_ok=1.
REQ-032 Check mode: in_data=0xA5, in_parity=0 -> out_ok=1, err_sticky=0; then in_data=0xA5, in_parity=1 -> out_ok=0, err_sticky=1, err_count=1.
REQ-033 Backpressure: accept 0x3C, hold out_ready=0 for 3 cycles -> in_ready=0, out_data=0x3C stable; then out_ready=1 with in_valid=1 and in_data=0x11 -> 0x11 is presented the next cycle, with no lost or duplicated beat.
REQ-034 Saturation: CNT_W=2, five failed checks -> err_count=3; err_clr coinciding with a sixth failure -> err_count=1, err_sticky=1.
REQ-035 ODD=1: generate with in_data=0x00 -> out_parity=1; check with in_data=0x00, in_parity=0 -> out_ok=0.
REQ-036 Reset mid-operation: rst=1 while FULL with out_ready=0 -> next cycle out_valid=0, err_sticky=0, err_count=0, in_ready=1.

Source files
------------

// File: rtl/parity_stream_unit.sv
// Parity generate/check stage with a one-entry registered output and a sticky error flag.
// Optional failure counter on err_count is built when PARITY_ERR_CNT_EN is defined.
module parity_stream_unit #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_parity,
    output logic              out_ok,
    output logic              err_sticky,
    input  logic              err_clr,
`ifdef PARITY_ERR_CNT_EN
    output logic [CNT_W-1:0]  err_count,
`endif
    output logic              dbg_state
);

    // Handshake: a beat moves on a side whenever valid && ready are both high at
    // a rising clk edge; valid never depends on ready, and in_ready is forced
    // high during reset so upstream is never stalled by a reset.
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam logic c_odd = 1'(ODD);

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_data;
    logic              r_parity;
    logic              r_ok;
    logic              r_err;

    logic w_accept;
    logic w_data_par;
    logic w_chk_ok;
    logic w_beat_par;
    logic w_beat_ok;
    logic w_fail;

    assign in_ready   = rst || (r_state == S_EMPTY) || out_ready;
    assign w_accept   = in_valid && in_ready && !rst;
    assign w_data_par = ^in_data;
    assign w_chk_ok   = ((w_data_par ^ in_parity) == c_odd);
    assign w_beat_par = mode ? in_parity : (w_data_par ^ c_odd);
    assign w_beat_ok  = mode ? w_chk_ok : 1'b1;
    assign w_fail     = w_accept && mode && !w_chk_ok;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_next_state = S_FULL;
            S_FULL: begin
                if (w_accept)       w_next_state = S_FULL;
                else if (out_ready) w_next_state = S_EMPTY;
            end
            default: w_next_state = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_next_state;
    end

    // Payload only loads on accept, so a stalled beat stays put.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_parity <= 1'b0;
            r_ok     <= 1'b0;
        end else if (w_accept) begin
            r_data   <= in_data;
            r_parity <= w_beat_par;
            r_ok     <= w_beat_ok;
        end
    end

    // A failure in the same cycle as err_clr wins, so no failure is ever lost.
    always_ff @(posedge clk) begin
        if (rst)          r_err <= 1'b0;
        else if (w_fail)  r_err <= 1'b1;
        else if (err_clr) r_err <= 1'b0;
    end

`ifdef PARITY_ERR_CNT_EN
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_fail) begin
            if (err_clr)                r_cnt <= CNT_W'(1);
            else if (r_cnt != c_cnt_max) r_cnt <= r_cnt + CNT_W'(1);
        end else if (err_clr) begin
            r_cnt <= '0;
        end
    end

    assign err_count = r_cnt;
`endif

    assign out_valid  = (r_state == S_FULL);
    assign out_data   = r_data;
    assign out_parity = r_parity;
    assign out_ok     = r_ok;
    assign err_sticky = r_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_parity_stream_unit.sv
// Directed plus random bench for parity_stream_unit: an even-parity unit (CNT_W=2)
// and an odd-parity unit share stimulus and are checked against a queue-based model.
module tb_parity_stream_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_parity;
    logic       out_ready;
    logic       err_clr;

    logic       in_ready0, out_valid0, out_parity0, out_ok0, err_sticky0, dbg0;
    logic [7:0] out_data0;
    logic       in_ready1, out_valid1, out_parity1, out_ok1, err_sticky1, dbg1;
    logic [7:0] out_data1;
`ifdef PARITY_ERR_CNT_EN
    logic [1:0] err_count0;
    logic [7:0] err_count1;
`endif

    int tests = 0;
    int fails = 0;

    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];
    logic       m_full;
    logic       m_err0, m_err1;
    logic [1:0] m_cnt0;
    logic [7:0] m_cnt1;

    always #5 clk = ~clk;

    parity_stream_unit #(.DATA_W(8), .ODD(0), .CNT_W(2)) u_dut0 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_parity(in_parity), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_parity(out_parity0),
        .out_ok(out_ok0), .err_sticky(err_sticky0), .err_clr(err_clr),
`ifdef PARITY_ERR_CNT_EN
        .err_count(err_count0),
`endif
        .dbg_state(dbg0)
    );

    parity_stream_unit #(.DATA_W(8), .ODD(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_parity(in_parity), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_parity(out_parity1),
        .out_ok(out_ok1), .err_sticky(err_sticky1), .err_clr(err_clr),
`ifdef PARITY_ERR_CNT_EN
        .err_count(err_count1),
`endif
        .dbg_state(dbg1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {data, parity, ok} for one beat.
    function automatic logic [9:0] model(input logic m, input logic [7:0] d,
                                         input logic p, input logic odd);
        logic x;
        x = 1'b0;
        for (int i = 0; i < 8; i++) x = x ^ d[i];
        if (m) model = {d, p, ((x ^ p) == odd)};
        else   model = {d, x ^ odd, 1'b1};
    endfunction

    task automatic drive(input logic v, input logic m, input logic [7:0] d,
                         input logic p, input logic r, input logic c);
        in_valid  = v;
        mode      = m;
        in_data   = d;
        in_parity = p;
        out_ready = r;
        err_clr   = c;
    endtask

    // Check all outputs against the model before the edge, then advance the model.
    task automatic tick();
        logic       acc;
        logic [9:0] e0, e1;
        @(negedge clk);
        chk("in_ready0", in_ready0, rst || !m_full || out_ready);
        chk("in_ready1", in_ready1, rst || !m_full || out_ready);
        chk("out_valid0", out_valid0, m_full);
        chk("out_valid1", out_valid1, m_full);
        chk("dbg_state0", dbg0, m_full);
        chk("err_sticky0", err_sticky0, m_err0);
        chk("err_sticky1", err_sticky1, m_err1);
`ifdef PARITY_ERR_CNT_EN
        chk("err_count0", err_count0, m_cnt0);
        chk("err_count1", err_count1, m_cnt1);
`endif
        if (m_full) begin
            if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                chk("beat0", {out_data0, out_parity0, out_ok0}, exp_q0[0]);
                chk("beat1", {out_data1, out_parity1, out_ok1}, exp_q1[0]);
            end
        end
        acc = in_valid && !rst && (!m_full || out_ready);
        e0  = model(mode, in_data, in_parity, 1'b0);
        e1  = model(mode, in_data, in_parity, 1'b1);
        if (rst) begin
            exp_q0.delete();
            exp_q1.delete();
        end else if (m_full && out_ready && exp_q0.size() > 0 && exp_q1.size() > 0) begin
            void'(exp_q0.pop_front());
            void'(exp_q1.pop_front());
        end
        if (acc) begin
            exp_q0.push_back(e0);
            exp_q1.push_back(e1);
        end
        if (rst) begin
            m_full = 1'b0; m_err0 = 1'b0; m_err1 = 1'b0; m_cnt0 = '0; m_cnt1 = '0;
        end else begin
            if (acc)            m_full = 1'b1;
            else if (out_ready) m_full = 1'b0;
            if (acc && mode && !e0[0]) begin
                m_err0 = 1'b1;
                m_cnt0 = err_clr ? 2'd1 : ((m_cnt0 == 2'd3) ? m_cnt0 : m_cnt0 + 2'd1);
            end else if (err_clr) begin
                m_err0 = 1'b0; m_cnt0 = '0;
            end
            if (acc && mode && !e1[0]) begin
                m_err1 = 1'b1;
                m_cnt1 = err_clr ? 8'd1 : ((m_cnt1 == 8'hFF) ? m_cnt1 : m_cnt1 + 8'd1);
            end else if (err_clr) begin
                m_err1 = 1'b0; m_cnt1 = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_full = 1'b0; m_err0 = 1'b0; m_err1 = 1'b0; m_cnt0 = '0; m_cnt1 = '0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        tick();
        rst = 1'b0;
        chk("rst_out_data", out_data0, 8'h00);
        chk("rst_out_parity", out_parity0, 1'b0);
        chk("rst_out_ok", out_ok0, 1'b0);
        chk("rst_in_ready", in_ready0, 1'b1);

        // Generate mode
        drive(1'b1, 1'b0, 8'h07, 1'b0, 1'b1, 1'b0); tick();
        chk("gen_valid", out_valid0, 1'b1);
        chk("gen_data", out_data0, 8'h07);
        chk("gen_parity", out_parity0, 1'b1);
        chk("gen_ok", out_ok0, 1'b1);

        // Check mode: good then bad parity
        drive(1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0); tick();
        chk("chk_good_ok", out_ok0, 1'b1);
        chk("chk_good_err", err_sticky0, 1'b0);
        drive(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0); tick();
        chk("chk_bad_ok", out_ok0, 1'b0);
        chk("chk_bad_err", err_sticky0, 1'b1);
`ifdef PARITY_ERR_CNT_EN
        chk("chk_bad_cnt", err_count0, 2'd1);
`endif
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1); tick();
        chk("err_clr", err_sticky0, 1'b0);

        // Backpressure: hold 0x3C while a different beat waits upstream
        drive(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", in_ready0, 1'b0);
            chk("bp_data", out_data0, 8'h3C);
        end
        drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0); tick();
        chk("bp_next_data", out_data0, 8'h11);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); tick();
        chk("bp_drained", out_valid0, 1'b0);

        // Saturation of the 2-bit counter, then clear colliding with a failure
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0); tick();
        end
`ifdef PARITY_ERR_CNT_EN
        chk("sat_cnt", err_count0, 2'd3);
`endif
        drive(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1); tick();
        chk("clr_vs_fail_err", err_sticky0, 1'b1);
`ifdef PARITY_ERR_CNT_EN
        chk("clr_vs_fail_cnt", err_count0, 2'd1);
`endif

        // Odd parity sense
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); tick();
        chk("odd_gen_parity", out_parity1, 1'b1);
        chk("even_gen_parity", out_parity0, 1'b0);
        drive(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0); tick();
        chk("odd_chk_ok", out_ok1, 1'b0);
        chk("even_chk_ok", out_ok0, 1'b1);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0));
            tick();
        end

        // Reset while holding a failed beat under backpressure
        drive(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0); tick();
        rst = 1'b1;
        #1;
        chk("rst_in_ready_during", in_ready0, 1'b1);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("midrst_valid", out_valid0, 1'b0);
        chk("midrst_err", err_sticky0, 1'b0);
        chk("midrst_data", out_data0, 8'h00);
        chk("midrst_in_ready", in_ready0, 1'b1);
`ifdef PARITY_ERR_CNT_EN
        chk("midrst_cnt", err_count0, 2'd0);
`endif
        tick();
        chk("final_queue", exp_q0.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
